// File: rtl/phys_free_list.sv
// Circular free list of physical register addresses: speculative alloc head, commit-side
// head for one-cycle mispredict recovery, and a tail that takes back superseded paddrs.
module phys_free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int PADDR_W   = $clog2(NUM_PREGS),
    parameter int DEPTH     = NUM_PREGS - NUM_AREGS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     branch_miss,
    input  logic                     alloc_req,
    output logic                     alloc_valid,
    output logic [PADDR_W-1:0]       alloc_paddr,
    input  logic                     commit_dealloc,
    input  logic                     free_web,
    input  logic [PADDR_W-1:0]       free_paddr,
    output logic [$clog2(DEPTH):0]   free_count,
    output logic                     empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PADDR_W-1:0] r_entry [DEPTH];
    logic [PTR_W-1:0]   r_spec_head;
    logic [PTR_W-1:0]   r_commit_head;
    logic [PTR_W-1:0]   r_tail;

    logic               w_alloc;
    logic               w_push;
    logic [PTR_W-1:0]   w_spec_head_nxt;
    logic [PTR_W-1:0]   w_commit_inc;

    assign free_count  = r_tail - r_spec_head;
    assign empty       = (free_count == '0);
    assign alloc_valid = !empty;
    assign alloc_paddr = r_entry[r_spec_head[IDX_W-1:0]];

    assign w_alloc      = alloc_req && alloc_valid && !branch_miss;
    // p0 is permanently the x0 mapping, so it never re-enters the list.
    assign w_push       = free_web && (free_paddr != '0);
    assign w_commit_inc = {{(PTR_W-1){1'b0}}, commit_dealloc};

    always_comb begin
        w_spec_head_nxt = r_spec_head;
        if (branch_miss) begin
            w_spec_head_nxt = r_commit_head + w_commit_inc;
        end else if (w_alloc) begin
            w_spec_head_nxt = r_spec_head + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_spec_head   <= '0;
            r_commit_head <= '0;
            r_tail        <= PTR_W'(DEPTH);
        end else begin
            r_spec_head   <= w_spec_head_nxt;
            r_commit_head <= r_commit_head + w_commit_inc;
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_entry[IDX_W'(i)] <= PADDR_W'(NUM_AREGS + i);
            end
        end else if (w_push) begin
            r_entry[r_tail[IDX_W-1:0]] <= free_paddr;
        end
    end

    a_no_overfill: assert property (@(posedge clk) disable iff (rst)
        !(w_push && (free_count == PTR_W'(DEPTH)) && !w_alloc));

    a_commit_behind_spec: assert property (@(posedge clk) disable iff (rst)
        !(commit_dealloc && (r_commit_head == r_spec_head)));

endmodule
